// File: rtl/redmule_zbuf_sched.sv
// Z output buffer sequencer: counts engine column fills up to the tile width,
// then drains the buffer row by row to the store streamer over valid/ready.
module redmule_zbuf_sched #(
  parameter  int unsigned Width       = 8,
  parameter  int unsigned Height      = 4,
  parameter  int unsigned NumPipeRegs = 3,
  localparam int unsigned Tile        = (NumPipeRegs + 1) * Height,
  localparam int unsigned RowsW       = $clog2(Width + 1),
  localparam int unsigned ColsW       = $clog2(Tile + 1),
  localparam int unsigned RowIdxW     = $clog2(Width)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               cfg_valid_i,
  input  logic [RowsW-1:0]   cfg_rows_i,
  input  logic [ColsW-1:0]   cfg_cols_i,
  input  logic               fill_i,
  output logic               full_o,
  output logic               empty_o,
  output logic               store_valid_o,
  input  logic               store_ready_i,
  output logic [RowIdxW-1:0] store_row_o,
  output logic [Tile-1:0]    store_strb_o,
  output logic               busy_o,
  output logic               overflow_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [RowsW-1:0] RowsMax = RowsW'(Width);
  localparam logic [ColsW-1:0] ColsMax = ColsW'(Tile);

  logic [1:0]         state_q, state_d;
  logic [RowsW-1:0]   rows_q, rows_d;
  logic [ColsW-1:0]   cols_q, cols_d;
  logic [Tile-1:0]    strb_q, strb_d;
  logic [ColsW-1:0]   fill_cnt_q, fill_cnt_d;
  logic [RowIdxW-1:0] row_q, row_d;
  logic               full_q, full_d;
  logic               valid_q, valid_d;
  logic               empty_q, empty_d;
  logic               overflow_q, overflow_d;

  logic               hs, last_row, cfg_accept;
  logic [RowsW-1:0]   rows_new;
  logic [ColsW-1:0]   cols_new;
  logic [Tile-1:0]    strb_new;

  // Zero and out-of-range requests saturate to the physical buffer size, so
  // the row and column counters can never wrap inside a tile.
  assign rows_new = (cfg_rows_i == '0 || cfg_rows_i > RowsMax) ? RowsMax : cfg_rows_i;
  assign cols_new = (cfg_cols_i == '0 || cfg_cols_i > ColsMax) ? ColsMax : cfg_cols_i;

  always_comb begin
    for (int unsigned i = 0; i < Tile; i++) begin
      strb_new[i] = (ColsW'(i) < cols_new);
    end
  end

  assign hs         = valid_q & store_ready_i;
  assign last_row   = (RowsW'(row_q) == rows_q - RowsW'(1));
  assign cfg_accept = cfg_valid_i &
                      ((state_q == IDLE) | ((state_q == DRAIN) & hs & last_row));

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case/if
    // tree leaves it unassigned; that is what keeps this block latch-free.
    state_d    = state_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    strb_d     = strb_q;
    fill_cnt_d = fill_cnt_q;
    row_d      = row_q;
    full_d     = full_q;
    valid_d    = valid_q;
    empty_d    = 1'b0;
    overflow_d = overflow_q | (fill_i & (state_q != FILL));

    case (state_q)
      IDLE: begin
        if (cfg_accept) begin
          state_d    = FILL;
          fill_cnt_d = '0;
        end
      end
      FILL: begin
        if (fill_i) begin
          if (fill_cnt_q == cols_q - ColsW'(1)) begin
            state_d    = DRAIN;
            fill_cnt_d = '0;
            full_d     = 1'b1;
            valid_d    = 1'b1;
            row_d      = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + ColsW'(1);
          end
        end
      end
      DRAIN: begin
        if (hs) begin
          if (last_row) begin
            state_d    = FILL;
            fill_cnt_d = '0;
            full_d     = 1'b0;
            valid_d    = 1'b0;
            empty_d    = 1'b1;
            row_d      = '0;
          end else begin
            row_d = row_q + RowIdxW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A capture on the last handshake only takes effect for the next tile,
    // because strb/rows/cols of the current tile are no longer needed.
    if (cfg_accept) begin
      rows_d = rows_new;
      cols_d = cols_new;
      strb_d = strb_new;
    end

    if (clear_i) begin
      state_d    = IDLE;
      rows_d     = RowsMax;
      cols_d     = ColsMax;
      strb_d     = '0;
      fill_cnt_d = '0;
      row_d      = '0;
      full_d     = 1'b0;
      valid_d    = 1'b0;
      empty_d    = 1'b0;
      overflow_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rows_q     <= RowsMax;
      cols_q     <= ColsMax;
      strb_q     <= '0;
      fill_cnt_q <= '0;
      row_q      <= '0;
      full_q     <= 1'b0;
      valid_q    <= 1'b0;
      empty_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      strb_q     <= strb_d;
      fill_cnt_q <= fill_cnt_d;
      row_q      <= row_d;
      full_q     <= full_d;
      valid_q    <= valid_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  assign full_o        = full_q;
  assign empty_o       = empty_q;
  assign store_valid_o = valid_q;
  assign store_row_o   = row_q;
  assign store_strb_o  = strb_q;
  assign busy_o        = (state_q != IDLE);
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_redmule_zbuf_sched.sv
// Directed bench for redmule_zbuf_sched: full, leftover, back-to-back and
// minimum tiles, overflow, clear and asynchronous reset.
module tb_redmule_zbuf_sched;

  logic        clk_i, rst_ni, clear_i, cfg_valid_i, fill_i, store_ready_i;
  logic [3:0]  cfg_rows_i;
  logic [4:0]  cfg_cols_i;
  logic        full_o, empty_o, store_valid_o, busy_o, overflow_o;
  logic [2:0]  store_row_o;
  logic [15:0] store_strb_o;

  int errors = 0;
  int checks = 0;

  redmule_zbuf_sched #(.Width(8), .Height(4), .NumPipeRegs(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .cfg_valid_i(cfg_valid_i), .cfg_rows_i(cfg_rows_i), .cfg_cols_i(cfg_cols_i),
    .fill_i(fill_i), .full_o(full_o), .empty_o(empty_o),
    .store_valid_o(store_valid_o), .store_ready_i(store_ready_i),
    .store_row_o(store_row_o), .store_strb_o(store_strb_o),
    .busy_o(busy_o), .overflow_o(overflow_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg(input logic [3:0] r, input logic [4:0] c);
    cfg_valid_i = 1'b1; cfg_rows_i = r; cfg_cols_i = c;
    step();
    cfg_valid_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; clear_i = 0; cfg_valid_i = 0; cfg_rows_i = 0; cfg_cols_i = 0;
    fill_i = 0; store_ready_i = 0;
    #12;
    checks++; if ({full_o, empty_o, store_valid_o, store_row_o, store_strb_o, busy_o, overflow_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got strb=%h row=%0d busy=%b valid=%b want all 0", store_strb_o, store_row_o, busy_o, store_valid_o);
    end
    #5 rst_ni = 1'b1;
    step();
    checks++; if (busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy: got %b want 0", busy_o);
    end
  endtask

  task automatic test_full_tile();
    store_ready_i = 1'b1;
    cfg(4'd0, 5'd0);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL full_busy: got %b want 1", busy_o); end
    fill_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++; if (full_o !== (i == 16)) begin
        errors++; $display("FAIL full_after_fill%0d: got %b want %b", i, full_o, (i == 16));
      end
    end
    fill_i = 1'b0;
    for (int r = 0; r < 8; r++) begin
      checks++; if (store_valid_o !== 1'b1 || store_row_o !== 3'(r) || store_strb_o !== 16'hFFFF || empty_o !== 1'b0) begin
        errors++; $display("FAIL full_row%0d: got valid=%b row=%0d strb=%h empty=%b want 1/%0d/ffff/0", r, store_valid_o, store_row_o, store_strb_o, empty_o, r);
      end
      step();
    end
    checks++; if (empty_o !== 1'b1 || full_o !== 1'b0 || store_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL full_empty_pulse: got empty=%b full=%b valid=%b busy=%b want 1/0/0/1", empty_o, full_o, store_valid_o, busy_o);
    end
    step();
    checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL full_empty_one_cycle: got %b want 0", empty_o); end
  endtask

  task automatic test_leftover();
    logic rdy_pat [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int exp_row = 0;
    do_clear();
    cfg(4'd3, 5'd5);
    fill_i = 1'b1;
    for (int i = 1; i <= 5; i++) step();
    fill_i = 1'b0;
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL left_full: got %b want 1", full_o); end
    for (int c = 0; c < 20 && exp_row < 3; c++) begin
      store_ready_i = (c < 6) ? rdy_pat[c] : 1'b1;
      checks++; if (store_valid_o !== 1'b1 || store_row_o !== 3'(exp_row) || store_strb_o !== 16'h001F) begin
        errors++; $display("FAIL left_cycle%0d: got valid=%b row=%0d strb=%h want 1/%0d/001f", c, store_valid_o, store_row_o, store_strb_o, exp_row);
      end
      step();
      if (store_ready_i) exp_row++;
    end
    checks++; if (exp_row !== 3 || empty_o !== 1'b1 || store_valid_o !== 1'b0) begin
      errors++; $display("FAIL left_done: got rows=%0d empty=%b valid=%b want 3/1/0", exp_row, empty_o, store_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    // Scheduler is in FILL with rows=3, cols=5 left from the previous tile.
    store_ready_i = 1'b1;
    fill_i = 1'b1;
    for (int i = 1; i <= 5; i++) step();
    fill_i = 1'b0;
    for (int r = 0; r < 3; r++) begin
      checks++; if (store_valid_o !== 1'b1 || store_row_o !== 3'(r)) begin
        errors++; $display("FAIL b2b_first_row%0d: got valid=%b row=%0d want 1/%0d", r, store_valid_o, store_row_o, r);
      end
      if (r == 0) begin cfg_valid_i = 1'b1; cfg_rows_i = 4'd1; cfg_cols_i = 5'd1; end
      if (r == 2) begin cfg_valid_i = 1'b1; cfg_rows_i = 4'd2; cfg_cols_i = 5'd0; end
      step();
      cfg_valid_i = 1'b0;
    end
    checks++; if (empty_o !== 1'b1 || full_o !== 1'b0 || store_valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_first_empty: got empty=%b full=%b valid=%b want 1/0/0", empty_o, full_o, store_valid_o);
    end
    fill_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++; if (full_o !== (i == 16) || empty_o !== 1'b0) begin
        errors++; $display("FAIL b2b_refill%0d: got full=%b empty=%b want %b/0", i, full_o, empty_o, (i == 16));
      end
    end
    fill_i = 1'b0;
    for (int r = 0; r < 2; r++) begin
      checks++; if (store_valid_o !== 1'b1 || store_row_o !== 3'(r) || store_strb_o !== 16'hFFFF) begin
        errors++; $display("FAIL b2b_second_row%0d: got valid=%b row=%0d strb=%h want 1/%0d/ffff", r, store_valid_o, store_row_o, store_strb_o, r);
      end
      step();
    end
    checks++; if (empty_o !== 1'b1 || store_valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_second_empty: got empty=%b valid=%b want 1/0", empty_o, store_valid_o);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    store_ready_i = 1'b0;
    fill_i = 1'b1;
    step();
    fill_i = 1'b0;
    checks++; if (overflow_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL ovf_idle: got ovf=%b busy=%b want 1/0", overflow_o, busy_o);
    end
    cfg(4'd1, 5'd2);
    fill_i = 1'b1;
    step();
    checks++; if (full_o !== 1'b0 || overflow_o !== 1'b1) begin
      errors++; $display("FAIL ovf_fill1: got full=%b ovf=%b want 0/1", full_o, overflow_o);
    end
    step();
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL ovf_fill2: got full=%b want 1", full_o); end
    step();
    fill_i = 1'b0;
    checks++; if (overflow_o !== 1'b1 || store_valid_o !== 1'b1 || store_row_o !== 3'd0) begin
      errors++; $display("FAIL ovf_drain: got ovf=%b valid=%b row=%0d want 1/1/0", overflow_o, store_valid_o, store_row_o);
    end
    store_ready_i = 1'b1;
    step();
    store_ready_i = 1'b0;
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b want 1", empty_o); end
    fill_i = 1'b1;
    step();
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL ovf_count1: got full=%b want 0", full_o); end
    step();
    fill_i = 1'b0;
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL ovf_count2: got full=%b want 1", full_o); end
    do_clear();
    checks++; if (overflow_o !== 1'b0 || busy_o !== 1'b0 || store_valid_o !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got ovf=%b busy=%b valid=%b want 0/0/0", overflow_o, busy_o, store_valid_o);
    end
  endtask

  task automatic test_min_tile();
    store_ready_i = 1'b1;
    cfg(4'd1, 5'd1);
    fill_i = 1'b1;
    step();
    fill_i = 1'b0;
    checks++; if (store_valid_o !== 1'b1 || full_o !== 1'b1 || store_strb_o !== 16'h0001 || store_row_o !== 3'd0) begin
      errors++; $display("FAIL min_drain: got valid=%b full=%b strb=%h row=%0d want 1/1/0001/0", store_valid_o, full_o, store_strb_o, store_row_o);
    end
    step();
    checks++; if (empty_o !== 1'b1 || store_valid_o !== 1'b0) begin
      errors++; $display("FAIL min_empty: got empty=%b valid=%b want 1/0", empty_o, store_valid_o);
    end
    do_clear();
  endtask

  task automatic test_clear_mid_drain();
    store_ready_i = 1'b1;
    cfg(4'd0, 5'd0);
    fill_i = 1'b1;
    for (int i = 1; i <= 16; i++) step();
    fill_i = 1'b0;
    for (int r = 0; r < 4; r++) step();
    checks++; if (store_valid_o !== 1'b1 || store_row_o !== 3'd4) begin
      errors++; $display("FAIL clr_at_row4: got valid=%b row=%0d want 1/4", store_valid_o, store_row_o);
    end
    do_clear();
    checks++; if ({full_o, empty_o, store_valid_o, store_row_o, store_strb_o, busy_o} !== '0) begin
      errors++; $display("FAIL clr_outputs: got valid=%b busy=%b full=%b row=%0d strb=%h want all 0", store_valid_o, busy_o, full_o, store_row_o, store_strb_o);
    end
    cfg(4'd1, 5'd1);
    fill_i = 1'b1;
    step();
    fill_i = 1'b0;
    checks++; if (store_valid_o !== 1'b1 || store_row_o !== 3'd0 || store_strb_o !== 16'h0001) begin
      errors++; $display("FAIL clr_restart: got valid=%b row=%0d strb=%h want 1/0/0001", store_valid_o, store_row_o, store_strb_o);
    end
    step();
    do_clear();
  endtask

  task automatic test_async_reset();
    store_ready_i = 1'b0;
    fill_i = 1'b1;
    step();
    cfg(4'd0, 5'd0);
    for (int i = 1; i <= 3; i++) step();
    fill_i = 1'b0;
    checks++; if (busy_o !== 1'b1 || overflow_o !== 1'b1) begin
      errors++; $display("FAIL arst_pre: got busy=%b ovf=%b want 1/1", busy_o, overflow_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if ({full_o, empty_o, store_valid_o, store_row_o, store_strb_o, busy_o, overflow_o} !== '0) begin
      errors++; $display("FAIL arst_immediate: got busy=%b ovf=%b strb=%h want all 0", busy_o, overflow_o, store_strb_o);
    end
    #2 rst_ni = 1'b1;
    step();
    cfg(4'd1, 5'd2);
    fill_i = 1'b1;
    step();
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL arst_fill1: got full=%b want 0", full_o); end
    step();
    fill_i = 1'b0;
    checks++; if (full_o !== 1'b1 || store_strb_o !== 16'h0003) begin
      errors++; $display("FAIL arst_fill2: got full=%b strb=%h want 1/0003", full_o, store_strb_o);
    end
  endtask

  initial begin
    test_reset();
    test_full_tile();
    test_leftover();
    test_back_to_back();
    test_overflow();
    test_min_tile();
    test_clear_mid_drain();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
